// File: rtl/ysyx_24070016_cpu_ctrl_pkg.sv
// Shared types and constants for the NPC multi-cycle sequencer.
//   state_e       : sequencer state encoding (HALT is a separate sticky flag)
//   RESET_PC_DEF  : default PC loaded at reset
//   NOP_INST      : IR contents after reset (addi x0,x0,0)
//   EBREAK_INST   : ebreak encoding, handy for IDU models and checkers
package ysyx_24070016_cpu_ctrl_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned CNT_W_DEF = 64;

    localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h8000_0000;
    localparam logic [XLEN-1:0] NOP_INST     = 32'h0000_0013;
    localparam logic [XLEN-1:0] EBREAK_INST  = 32'h0010_0073;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_WAIT   = 2'd1,
        ST_DECODE = 2'd2,
        ST_EXEC   = 2'd3
    } state_e;

endpackage

// File: rtl/ysyx_24070016_cpu_ctrl_if.sv
// Instruction-memory valid/ready port between the sequencer and IFU memory.
//   imem_req_valid/ready : fetch request handshake
//   imem_addr            : fetch address
//   imem_rsp_valid/data  : fetch response (no backpressure)
// master = core side, slave = memory side.
interface ysyx_24070016_cpu_ctrl_if;
    import ysyx_24070016_cpu_ctrl_pkg::*;

    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_addr;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;

    modport master (
        output imem_req_valid,
        output imem_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );

endinterface

// File: rtl/ysyx_24070016_perf_cnt.sv
// Free-running performance counter, wraps modulo 2^CNT_W.
//   clk, rst_n : clock, async active-low reset (clears to 0)
//   en         : counter enabled
//   inc        : increment request this cycle (counts when en && inc)
//   cnt        : registered count
module ysyx_24070016_perf_cnt #(
    parameter int unsigned CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count
    always_comb begin
        cnt_d = cnt_q;
        if (en && inc) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/ysyx_24070016_cpu_ctrl.sv
// Multi-cycle sequencer for the NPC core: FETCH -> WAIT -> DECODE -> EXEC.
// Holds PC and IR, gates the RF write to the single EXEC cycle, commits the
// EXU next PC, and halts permanently on ebreak (left only by reset).
//   clk, rst_n          : clock, async active-low reset
//   imem (master)       : instruction-memory request/response port
//   ir                  : latched instruction, feeds IDU
//   dec_rf_wen          : IDU rf_wen (combinational from ir)
//   dec_ebreak          : IDU ebreak (combinational from ir)
//   exu_next_pc         : next PC from EXU, committed in EXEC
//   pc                  : current PC, feeds EXU
//   rf_wen_q            : gated RF write enable (high only in EXEC)
//   halt                : sticky halt after ebreak
//   cycle_cnt           : cycles since reset, frozen while halted
//   instret_cnt         : retired instructions, ebreak included
module ysyx_24070016_cpu_ctrl
    import ysyx_24070016_cpu_ctrl_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
    parameter int unsigned     CNT_W    = CNT_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    ysyx_24070016_cpu_ctrl_if.master imem,
    output logic [XLEN-1:0]          ir,
    input  logic                     dec_rf_wen,
    input  logic                     dec_ebreak,
    input  logic [XLEN-1:0]          exu_next_pc,
    output logic [XLEN-1:0]          pc,
    output logic                     rf_wen_q,
    output logic                     halt,
    output logic [CNT_W-1:0]         cycle_cnt,
    output logic [CNT_W-1:0]         instret_cnt
);

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] ir_q, ir_d;
    logic            halt_q, halt_d;

    logic            req_valid_c;
    logic            rf_wen_c;
    logic            retire_c;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= NOP_INST;
            halt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            halt_q  <= halt_d;
        end
    end

    // Next-state and handshake/control outputs; everything is frozen once halted
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        halt_d      = halt_q;
        req_valid_c = 1'b0;
        rf_wen_c    = 1'b0;
        retire_c    = 1'b0;

        if (!halt_q) begin
            unique case (state_q)
                ST_FETCH: begin
                    req_valid_c = 1'b1;
                    if (imem.imem_req_ready) begin
                        state_d = ST_WAIT;
                    end
                end
                // Responses are only accepted here, so a same-cycle response
                // to the request handshake or a stale one after reset is dropped
                ST_WAIT: begin
                    if (imem.imem_rsp_valid) begin
                        ir_d    = imem.imem_rsp_data;
                        state_d = ST_DECODE;
                    end
                end
                // ebreak retires here and parks the FSM in DECODE for good
                ST_DECODE: begin
                    if (dec_ebreak) begin
                        halt_d   = 1'b1;
                        retire_c = 1'b1;
                    end else begin
                        state_d = ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    rf_wen_c = dec_rf_wen;
                    pc_d     = exu_next_pc;
                    retire_c = 1'b1;
                    state_d  = ST_FETCH;
                end
                default: begin
                    state_d = ST_FETCH;
                end
            endcase
        end
    end

    assign imem.imem_req_valid = req_valid_c;
    assign imem.imem_addr      = pc_q;
    assign rf_wen_q            = rf_wen_c;
    assign ir                  = ir_q;
    assign pc                  = pc_q;
    assign halt                = halt_q;

    // Cycle counter: runs until the halt flag is set
    ysyx_24070016_perf_cnt #(
        .CNT_W (CNT_W)
    ) u_cycle_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (~halt_q),
        .inc   (1'b1),
        .cnt   (cycle_cnt)
    );

    // Retired-instruction counter: EXEC completion or ebreak in DECODE
    ysyx_24070016_perf_cnt #(
        .CNT_W (CNT_W)
    ) u_instret_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (1'b1),
        .inc   (retire_c),
        .cnt   (instret_cnt)
    );

endmodule

// File: tb/tb_ysyx_24070016_cpu_ctrl.sv
// Self-checking bench for ysyx_24070016_cpu_ctrl. The bench plays memory, IDU
// and EXU; each instruction follows a timeline derived from its ready delay and
// response latency, against which every cycle's outputs are compared.
module tb_ysyx_24070016_cpu_ctrl;
    import ysyx_24070016_cpu_ctrl_pkg::*;

    localparam logic [31:0] RST_PC = 32'h8000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] EBRK   = 32'h0010_0073;
    localparam logic [31:0] DEAD   = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] ir;
    logic        dec_rf_wen;
    logic        dec_ebreak;
    logic [31:0] exu_next_pc;
    logic [31:0] pc;
    logic        rf_wen_q;
    logic        halt;
    logic [63:0] cycle_cnt;
    logic [63:0] instret_cnt;

    always #5 clk = ~clk;

    ysyx_24070016_cpu_ctrl_if imem_if ();

    // IDU stand-in: writes rd unless rd is x0; ebreak by exact encoding
    assign dec_ebreak = (ir == EBRK);
    assign dec_rf_wen = (ir[11:7] != 5'd0);

    ysyx_24070016_cpu_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem        (imem_if),
        .ir          (ir),
        .dec_rf_wen  (dec_rf_wen),
        .dec_ebreak  (dec_ebreak),
        .exu_next_pc (exu_next_pc),
        .pc          (pc),
        .rf_wen_q    (rf_wen_q),
        .halt        (halt),
        .cycle_cnt   (cycle_cnt),
        .instret_cnt (instret_cnt)
    );

    int          checks    = 0;
    int          failures  = 0;
    int          rf_pulses = 0;
    logic [31:0] exp_pc;
    logic [31:0] exp_ir;
    logic [63:0] exp_cyc;
    logic [63:0] exp_ret;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic writes_rd(input logic [31:0] inst);
        logic [31:0] t;
        t = inst;
        return (t[11:7] != 5'd0);
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [31:0] v;
        if ($urandom_range(0, 1) == 0) begin
            v = {12'($urandom), 5'($urandom), 3'b000, 5'($urandom), 7'h13};
        end else begin
            v = $urandom;
        end
        if (v == EBRK) v = NOP;
        return v;
    endfunction

    // One instruction: r cycles of ready=0 in FETCH, response l cycles after
    // the handshake, then DECODE and (unless ebreak) EXEC.
    task automatic run_instr(input logic [31:0] inst, input int r, input int l,
                             input logic [31:0] npc, input bit spur);
        bit brk;
        int total;
        bit in_fetch, in_wait, in_exec;
        brk   = (inst == EBRK);
        total = brk ? r + l + 2 : r + l + 3;
        for (int c = 0; c < total; c++) begin
            in_fetch = (c <= r);
            in_wait  = (c > r) && (c <= r + l);
            in_exec  = (c == r + l + 2);
            imem_if.imem_req_ready = in_fetch ? (c == r) : 1'($urandom_range(0, 1));
            if (in_wait) begin
                imem_if.imem_rsp_valid = (c == r + l);
                imem_if.imem_rsp_data  = (c == r + l) ? inst : $urandom;
            end else begin
                imem_if.imem_rsp_valid = spur ? 1'($urandom_range(0, 1)) : 1'b0;
                imem_if.imem_rsp_data  = DEAD;
            end
            exu_next_pc = in_exec ? npc : $urandom;
            #1;
            check_eq("req_valid", 64'(imem_if.imem_req_valid), 64'(in_fetch));
            if (in_fetch) check_eq("imem_addr", 64'(imem_if.imem_addr), 64'(exp_pc));
            check_eq("rf_wen", 64'(rf_wen_q), 64'(in_exec && writes_rd(inst)));
            if (rf_wen_q) rf_pulses++;
            check_eq("pc", 64'(pc), 64'(exp_pc));
            check_eq("ir", 64'(ir), 64'(exp_ir));
            check_eq("halt", 64'(halt), 64'd0);
            check_eq("cycle_cnt", cycle_cnt, exp_cyc);
            check_eq("instret_cnt", instret_cnt, exp_ret);
            @(negedge clk);
            exp_cyc++;
            if (c == r + l) exp_ir = inst;
            if (in_exec || (brk && c == total - 1)) exp_ret++;
            if (in_exec) exp_pc = npc;
        end
    endtask

    initial begin
        logic [63:0] c0, i0;
        int          p0;
        logic [31:0] inst;

        rst_n                  = 1'b0;
        imem_if.imem_req_ready = 1'b0;
        imem_if.imem_rsp_valid = 1'b0;
        imem_if.imem_rsp_data  = 32'h0;
        exu_next_pc            = 32'h0;
        repeat (2) @(negedge clk);

        check_eq("rst_pc", 64'(pc), 64'(RST_PC));
        check_eq("rst_ir", 64'(ir), 64'(NOP));
        check_eq("rst_halt", 64'(halt), 64'd0);
        check_eq("rst_cycle", cycle_cnt, 64'd0);
        check_eq("rst_instret", instret_cnt, 64'd0);
        check_eq("rst_rf_wen", 64'(rf_wen_q), 64'd0);

        rst_n   = 1'b1;
        exp_pc  = RST_PC;
        exp_ir  = NOP;
        exp_cyc = 64'd0;
        exp_ret = 64'd0;

        // addi x1,x0,1 with ready=1 and 1-cycle response
        run_instr(32'h0010_0093, 0, 1, 32'h8000_0004, 1'b0);
        check_eq("t1_pc", 64'(pc), 64'h8000_0004);
        check_eq("t1_rf_pulses", 64'(rf_pulses), 64'd1);

        // ready held low for 3 cycles in FETCH
        run_instr(32'h0020_0113, 3, 1, 32'h8000_0008, 1'b0);

        // 10 back-to-back addi with 3-cycle response latency
        c0 = cycle_cnt;
        i0 = instret_cnt;
        p0 = rf_pulses;
        for (int i = 0; i < 10; i++) begin
            inst = {12'(i), 5'd0, 3'b000, 5'(i % 31 + 1), 7'h13};
            run_instr(inst, 0, 3, exp_pc + 32'd4, 1'b0);
        end
        check_eq("t6_instret", instret_cnt - i0, 64'd10);
        check_eq("t6_cycles", cycle_cnt - c0, 64'd60);
        check_eq("t6_rf_pulses", 64'(rf_pulses - p0), 64'd10);

        // Randomized delays, PCs (misaligned allowed) and spurious responses
        for (int i = 0; i < 40; i++) begin
            run_instr(rand_inst(), int'($urandom_range(0, 3)), int'($urandom_range(1, 4)),
                      ($urandom_range(0, 1) != 0) ? exp_pc + 32'd4 : $urandom, 1'b1);
        end

        // Reset asserted while waiting for a response
        imem_if.imem_req_ready = 1'b1;
        imem_if.imem_rsp_valid = 1'b0;
        @(negedge clk);
        imem_if.imem_req_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_eq("t5_rst_pc", 64'(pc), 64'(RST_PC));
        check_eq("t5_rst_ir", 64'(ir), 64'(NOP));
        check_eq("t5_rst_cycle", cycle_cnt, 64'd0);
        check_eq("t5_rst_instret", instret_cnt, 64'd0);
        @(negedge clk);
        rst_n   = 1'b1;
        exp_pc  = RST_PC;
        exp_ir  = NOP;
        exp_cyc = 64'd0;
        exp_ret = 64'd0;
        // Late response arrives while back in FETCH
        for (int i = 0; i < 2; i++) begin
            imem_if.imem_rsp_valid = 1'b1;
            imem_if.imem_rsp_data  = DEAD;
            #1;
            check_eq("t5_req_valid", 64'(imem_if.imem_req_valid), 64'd1);
            check_eq("t5_addr", 64'(imem_if.imem_addr), 64'(RST_PC));
            check_eq("t5_ir", 64'(ir), 64'(NOP));
            @(negedge clk);
            exp_cyc++;
        end

        // ebreak: halts after DECODE, everything frozen afterwards
        p0 = rf_pulses;
        run_instr(EBRK, 0, 1, $urandom, 1'b1);
        for (int i = 0; i < 6; i++) begin
            imem_if.imem_req_ready = 1'($urandom_range(0, 1));
            imem_if.imem_rsp_valid = 1'($urandom_range(0, 1));
            imem_if.imem_rsp_data  = DEAD;
            exu_next_pc            = $urandom;
            #1;
            check_eq("t3_halt", 64'(halt), 64'd1);
            check_eq("t3_req_valid", 64'(imem_if.imem_req_valid), 64'd0);
            check_eq("t3_rf_wen", 64'(rf_wen_q), 64'd0);
            check_eq("t3_ir", 64'(ir), 64'(EBRK));
            check_eq("t3_pc", 64'(pc), 64'(RST_PC));
            check_eq("t3_cycle", cycle_cnt, 64'd5);
            check_eq("t3_instret", instret_cnt, 64'd1);
            @(negedge clk);
        end
        check_eq("t3_rf_pulses", 64'(rf_pulses - p0), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
